cpu_memory_responder: RTL and testbench

- Memory-side responder for the `control_matrix` soft CPU. It serves the CPU's instruction fetches and its data read/write requests.
- It holds a loadable instruction store (26-bit words) and a byte-wide data RAM.
- Replaces bench-side instruction lookup with synthesizable, cycle-accurate memory behaviour; sits between `control_matrix` and program-load logic.

---
 rtl/cpu_memory_responder.sv | 125 ++++++++++++
 tb/tb_cpu_memory_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_memory_responder.sv
// Memory-side responder for the control_matrix CPU: registered instruction fetch
// from a loadable 26-bit store, plus a byte RAM with a wait-stated read FSM.
module cpu_memory_responder #(
  parameter int unsigned INSTR_DEPTH = 256,
  parameter int unsigned DATA_DEPTH  = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instructionPointer,
  output logic [25:0] instruction,
  output logic        instructionFault,
  input  logic        loadEnable,
  input  logic [15:0] loadAddress,
  input  logic [25:0] loadData,
  input  logic [15:0] addressIn,
  input  logic        readValueIn,
  output logic [7:0]  valueIn,
  output logic        valueInValid,
  input  logic [15:0] addressOut,
  input  logic [7:0]  valueOut,
  input  logic        writeValueOut,
  output logic        busy
);

  localparam int unsigned IAW = (INSTR_DEPTH > 1) ? $clog2(INSTR_DEPTH) : 1;
  localparam int unsigned DAW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} readState_t;

  readState_t  state, nextState;
  logic [3:0]  waitCount, nextWaitCount;
  logic [15:0] readAddress, nextReadAddress;

  logic [25:0] instrStore [INSTR_DEPTH];
  logic [7:0]  dataRam    [DATA_DEPTH];

  logic fetchInRange, loadInRange, writeInRange, readInRange;

  // Full 16-bit compares so out-of-range addresses never alias into the arrays.
  assign fetchInRange = 32'(instructionPointer) < INSTR_DEPTH;
  assign loadInRange  = 32'(loadAddress) < INSTR_DEPTH;
  assign writeInRange = 32'(addressOut) < DATA_DEPTH;
  assign readInRange  = 32'(readAddress) < DATA_DEPTH;

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (loadEnable && loadInRange)
      instrStore[loadAddress[IAW-1:0]] <= loadData;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instruction      <= '0;
      instructionFault <= 1'b0;
    end else if (!fetchInRange) begin
      instruction      <= '0;
      instructionFault <= 1'b1;
    end else begin
      instructionFault <= 1'b0;
      if (loadEnable && loadAddress == instructionPointer)
        instruction <= loadData;
      else
        instruction <= instrStore[instructionPointer[IAW-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && writeValueOut && writeInRange)
      dataRam[addressOut[DAW-1:0]] <= valueOut;
  end

  always_comb begin
    nextState       = state;
    nextWaitCount   = waitCount;
    nextReadAddress = readAddress;
    case (state)
      IDLE: begin
        if (readValueIn) begin
          nextReadAddress = addressIn;
          if (WAIT_STATES == 0) begin
            nextState = RESPOND;
          end else begin
            nextWaitCount = WAIT_LOAD;
            nextState     = WAIT;
          end
        end
      end
      WAIT: begin
        nextWaitCount = waitCount - 4'd1;
        if (waitCount <= 4'd1)
          nextState = RESPOND;
      end
      RESPOND: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      waitCount    <= '0;
      readAddress  <= '0;
      valueIn      <= '0;
      valueInValid <= 1'b0;
    end else begin
      state        <= nextState;
      waitCount    <= nextWaitCount;
      readAddress  <= nextReadAddress;
      valueInValid <= (state == RESPOND);
      if (state == RESPOND) begin
        // A write landing on the same edge is forwarded so read-after-write stays coherent.
        if (!readInRange)
          valueIn <= '0;
        else if (writeValueOut && addressOut == readAddress)
          valueIn <= valueOut;
        else
          valueIn <= dataRam[readAddress[DAW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_cpu_memory_responder.sv
// Randomized bench for cpu_memory_responder: two instances (WAIT_STATES 0 and 1)
// checked every cycle against a transaction-level reference model.
module tb_cpu_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ip, la;
  logic        ldEn;
  logic [25:0] ld;
  logic        rd [2];
  logic [15:0] ra [2];
  logic [15:0] wa [2];
  logic [7:0]  wd [2];
  logic        we [2];

  logic [25:0] instr  [2];
  logic        fault  [2];
  logic [7:0]  vIn    [2];
  logic        vValid [2];
  logic        busy   [2];

  always #5 clk = ~clk;

  cpu_memory_responder #(.INSTR_DEPTH(256), .DATA_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clock(clk), .reset(reset),
    .instructionPointer(ip), .instruction(instr[0]), .instructionFault(fault[0]),
    .loadEnable(ldEn), .loadAddress(la), .loadData(ld),
    .addressIn(ra[0]), .readValueIn(rd[0]), .valueIn(vIn[0]), .valueInValid(vValid[0]),
    .addressOut(wa[0]), .valueOut(wd[0]), .writeValueOut(we[0]), .busy(busy[0])
  );

  cpu_memory_responder #(.INSTR_DEPTH(256), .DATA_DEPTH(256), .WAIT_STATES(1)) dut1 (
    .clock(clk), .reset(reset),
    .instructionPointer(ip), .instruction(instr[1]), .instructionFault(fault[1]),
    .loadEnable(ldEn), .loadAddress(la), .loadData(ld),
    .addressIn(ra[1]), .readValueIn(rd[1]), .valueIn(vIn[1]), .valueInValid(vValid[1]),
    .addressOut(wa[1]), .valueOut(wd[1]), .writeValueOut(we[1]), .busy(busy[1])
  );

  // Reference model state
  int          ws [2] = '{0, 1};
  logic [25:0] imem [256];
  logic [7:0]  dmem [2][256];
  bit          pend [2];
  int          rEdge [2];
  logic [15:0] rAddr [2];
  logic [7:0]  eVal [2];
  bit          eValid [2];
  bit          eBusy [2];
  logic [25:0] eInstr;
  bit          eFault;
  int          cyc = 0;
  int          nChecks = 0;
  int          nErrors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic idle();
    ldEn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0;
      we[d] = 1'b0;
    end
  endtask

  task automatic step();
    bit acc;
    @(posedge clk);
    cyc++;
    if (reset) begin
      eInstr = '0; eFault = 1'b0;
    end else if (ip < 256) begin
      eInstr = (ldEn && la == ip) ? ld : imem[ip[7:0]];
      eFault = 1'b0;
    end else begin
      eInstr = '0; eFault = 1'b1;
    end
    if (ldEn && la < 256) imem[la[7:0]] = ld;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        pend[d] = 0; eVal[d] = '0; eValid[d] = 0; eBusy[d] = 0;
      end else begin
        acc = rd[d] && !pend[d];
        if (we[d] && wa[d] < 256) dmem[d][wa[d][7:0]] = wd[d];
        eValid[d] = 0;
        if (pend[d] && cyc == rEdge[d]) begin
          eValid[d] = 1;
          eVal[d]   = (rAddr[d] < 256) ? dmem[d][rAddr[d][7:0]] : 8'h00;
          pend[d]   = 0;
        end
        if (acc) begin
          pend[d]  = 1;
          rAddr[d] = ra[d];
          rEdge[d] = cyc + ws[d] + 1;
        end
        eBusy[d] = pend[d] && (cyc < rEdge[d]);
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      checkVal($sformatf("instruction[%0d]", d), 32'(instr[d]), 32'(eInstr));
      checkVal($sformatf("instructionFault[%0d]", d), 32'(fault[d]), 32'(eFault));
      checkVal($sformatf("valueIn[%0d]", d), 32'(vIn[d]), 32'(eVal[d]));
      checkVal($sformatf("valueInValid[%0d]", d), 32'(vValid[d]), 32'(eValid[d]));
      checkVal($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(eBusy[d]));
    end
  endtask

  task automatic setWrite(input int d, input logic [15:0] a, input logic [7:0] v);
    we[d] = 1'b1; wa[d] = a; wd[d] = v;
  endtask

  task automatic setRead(input int d, input logic [15:0] a);
    rd[d] = 1'b1; ra[d] = a;
  endtask

  initial begin
    reset = 1'b1; ip = '0; la = '0; ld = '0;
    for (int d = 0; d < 2; d++) begin
      ra[d] = '0; wa[d] = '0; wd[d] = '0;
      pend[d] = 0; rEdge[d] = 0; rAddr[d] = '0;
    end
    idle();
    step(); step();
    reset = 1'b0;

    // Preload everything so the model is fully defined; fetch the word being loaded.
    for (int i = 0; i < 256; i++) begin
      ldEn = 1'b1; la = 16'(i); ld = 26'($urandom); ip = 16'(i);
      for (int d = 0; d < 2; d++) setWrite(d, 16'(i), 8'($urandom));
      step();
    end
    idle();

    // Program load and fetch
    ldEn = 1'b1; la = 16'd0; ld = 26'b00010000000000000000000000; step();
    la = 16'd1; ld = 26'b00010000101000000000000001; step();
    ldEn = 1'b0; ip = 16'd1; step(); step();
    ldEn = 1'b1; la = 16'd6; ld = 26'b01010011000000000000000100; ip = 16'd6; step();
    ldEn = 1'b0; step();
    ip = 16'd300; step(); step();
    ldEn = 1'b1; la = 16'd300; ld = 26'h3ffffff; ip = 16'd44; step();
    ldEn = 1'b0; ip = 16'hffff; step();
    ip = 16'd0; step();

    // Write then read with wait states
    for (int d = 0; d < 2; d++) setWrite(d, 16'h10, 8'hA5);
    step(); idle();
    setRead(1, 16'h10); step(); idle();
    step(); step(); step();

    // Forwarded write in RESPOND-entry cycle, plus a read attempt while busy
    setWrite(1, 16'h20, 8'h11); step(); idle();
    setRead(1, 16'h20); step();
    setRead(1, 16'h21); step(); idle();
    setWrite(1, 16'h20, 8'h3C); step(); idle();
    step(); step();

    // Reset during WAIT, with a write discarded in the reset cycle
    setRead(1, 16'h10); step(); idle();
    reset = 1'b1; setWrite(1, 16'h10, 8'hFF); step(); idle();
    reset = 1'b0; step(); step();
    setRead(1, 16'h10); step(); idle();
    step(); step(); step();

    // Zero wait states and out-of-range addresses
    setRead(0, 16'h10); step(); idle();
    step();
    setRead(0, 16'h1234); step(); idle();
    step();
    setWrite(0, 16'h1234, 8'h77); step(); idle();
    setRead(0, 16'h0034); step(); idle();
    step(); step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      ip   = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      ldEn = ($urandom_range(0, 3) == 0);
      la   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      ld   = 26'($urandom);
      for (int d = 0; d < 2; d++) begin
        rd[d] = ($urandom_range(0, 2) == 0);
        ra[d] = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
        we[d] = ($urandom_range(0, 1) == 0);
        case ($urandom_range(0, 3))
          0:       wa[d] = rAddr[d];
          1:       wa[d] = 16'($urandom);
          default: wa[d] = 16'($urandom_range(0, 255));
        endcase
        wd[d] = 8'($urandom);
      end
      step();
    end
    reset = 1'b0; idle();
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
